usb_txn_ctrl: RTL and testbench

- Host-side transaction sequencer for one USB OUT or IN transaction at a time.
- Drives the transmit blocks (token, data and handshake senders) and the receive-data FSM.
- Sits between the read/write request logic and the bit-level tx/rx datapath.
- Handles ACK/NAK/timeout outcomes and retries up to MAX_RETRY attempts before reporting failure.

---
 rtl/usb_txn_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_usb_txn_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_txn_ctrl.sv
// usb_txn_ctrl: host-side sequencer for a single USB OUT or IN transaction.
// Issues token / data / handshake sends, arms the receive-data FSM, and
// retries on NAK, bad PID or receive failure until the attempt budget runs out.
module usb_txn_ctrl #(
    parameter int MAX_RETRY = 8,
    parameter int PID_W     = 4
) (
    input  logic             clk,
    input  logic             rst_L,
    input  logic             pause,
    input  logic             txn_start,
    input  logic             txn_dir,
    output logic             txn_done,
    output logic             txn_ok,
    output logic             tx_token_start,
    output logic [PID_W-1:0] tx_token_pid,
    output logic             tx_data_start,
    output logic             tx_hs_start,
    output logic [PID_W-1:0] tx_hs_pid,
    input  logic             tx_done,
    output logic             rx_start,
    output logic             rx_hs_mode,
    input  logic             rx_success,
    input  logic             rx_fail,
    input  logic [PID_W-1:0] rx_pid,
    output logic [3:0]       retry_cnt
);

    localparam logic [PID_W-1:0] PID_OUT = PID_W'(4'b0001);
    localparam logic [PID_W-1:0] PID_IN  = PID_W'(4'b1001);
    localparam logic [PID_W-1:0] PID_ACK = PID_W'(4'b0010);
    localparam logic [PID_W-1:0] PID_NAK = PID_W'(4'b1010);
    localparam logic [3:0]       MAX_RETRY_C = 4'(MAX_RETRY);

    // Direction encoding of txn_dir / dir_q.
    localparam logic DIR_OUT = 1'b0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TOKEN,
        S_TOKEN_WAIT,
        S_DATA_TX,
        S_DATA_WAIT,
        S_RX_START,
        S_RX_WAIT,
        S_HS_TX,
        S_HS_WAIT,
        S_RETRY,
        S_FINISH
    } state_e;

    state_e           state_q,     state_d;
    logic             dir_q,       dir_d;
    logic             ok_q,        ok_d;
    logic [3:0]       retry_cnt_q, retry_cnt_d;
    logic [PID_W-1:0] hs_pid_q,    hs_pid_d;
    logic             hs_mode_q,   hs_mode_d;

    // Next-state, counter and latch updates; everything holds while paused.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        dir_d       = dir_q;
        ok_d        = ok_q;
        retry_cnt_d = retry_cnt_q;
        hs_pid_d    = hs_pid_q;
        hs_mode_d   = hs_mode_q;

        if (!pause) begin
            unique case (state_q)
                S_IDLE: begin
                    if (txn_start) begin
                        dir_d       = txn_dir;
                        ok_d        = 1'b0;
                        retry_cnt_d = '0;
                        // Receiver expects a handshake after an OUT, data after an IN.
                        hs_mode_d   = (txn_dir == DIR_OUT);
                        state_d     = S_TOKEN;
                    end
                end
                S_TOKEN: begin
                    retry_cnt_d = retry_cnt_q + 4'd1;
                    state_d     = S_TOKEN_WAIT;
                end
                S_TOKEN_WAIT: begin
                    if (tx_done) begin
                        state_d = (dir_q == DIR_OUT) ? S_DATA_TX : S_RX_START;
                    end
                end
                S_DATA_TX: begin
                    state_d = S_DATA_WAIT;
                end
                S_DATA_WAIT: begin
                    if (tx_done) begin
                        state_d = S_RX_START;
                    end
                end
                S_RX_START: begin
                    state_d = S_RX_WAIT;
                end
                S_RX_WAIT: begin
                    // A simultaneous success and fail is treated as a fail.
                    if (dir_q == DIR_OUT) begin
                        if (rx_fail) begin
                            state_d = S_RETRY;
                        end else if (rx_success) begin
                            if (rx_pid == PID_ACK) begin
                                ok_d    = 1'b1;
                                state_d = S_FINISH;
                            end else begin
                                state_d = S_RETRY;
                            end
                        end
                    end else begin
                        if (rx_fail) begin
                            hs_pid_d = PID_NAK;
                            state_d  = S_HS_TX;
                        end else if (rx_success) begin
                            hs_pid_d = PID_ACK;
                            state_d  = S_HS_TX;
                        end
                    end
                end
                S_HS_TX: begin
                    state_d = S_HS_WAIT;
                end
                S_HS_WAIT: begin
                    if (tx_done) begin
                        if (hs_pid_q == PID_ACK) begin
                            ok_d    = 1'b1;
                            state_d = S_FINISH;
                        end else begin
                            state_d = S_RETRY;
                        end
                    end
                end
                S_RETRY: begin
                    if (retry_cnt_q == MAX_RETRY_C) begin
                        ok_d    = 1'b0;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_TOKEN;
                    end
                end
                S_FINISH: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Start pulses fire for one unpaused cycle in their issuing state.
    always_comb begin
        tx_token_start = !pause && (state_q == S_TOKEN);
        tx_data_start  = !pause && (state_q == S_DATA_TX);
        tx_hs_start    = !pause && (state_q == S_HS_TX);
        rx_start       = !pause && (state_q == S_RX_START);
        txn_done       = !pause && (state_q == S_FINISH);
        txn_ok         = txn_done && ok_q;
    end

    assign tx_token_pid = dir_q ? PID_IN : PID_OUT;
    assign tx_hs_pid    = hs_pid_q;
    assign rx_hs_mode   = hs_mode_q;
    assign retry_cnt    = retry_cnt_q;

    // State register and latched transaction context.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q     <= S_IDLE;
            dir_q       <= DIR_OUT;
            ok_q        <= 1'b0;
            retry_cnt_q <= '0;
            hs_pid_q    <= PID_ACK;
            hs_mode_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            dir_q       <= dir_d;
            ok_q        <= ok_d;
            retry_cnt_q <= retry_cnt_d;
            hs_pid_q    <= hs_pid_d;
            hs_mode_q   <= hs_mode_d;
        end
    end

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Self-checking bench for usb_txn_ctrl: a table of per-cycle vectors for a
// clean OUT and an IN-with-retry transaction, then hand-written sequences for
// NAK retries, retry exhaustion, pause, ignored txn_start and async reset.
module tb_usb_txn_ctrl;

    logic       clk;
    logic       rst_L;
    logic       pause;
    logic       txn_start;
    logic       txn_dir;
    logic       txn_done;
    logic       txn_ok;
    logic       tx_token_start;
    logic [3:0] tx_token_pid;
    logic       tx_data_start;
    logic       tx_hs_start;
    logic [3:0] tx_hs_pid;
    logic       tx_done;
    logic       rx_start;
    logic       rx_hs_mode;
    logic       rx_success;
    logic       rx_fail;
    logic [3:0] rx_pid;
    logic [3:0] retry_cnt;

    usb_txn_ctrl #(.MAX_RETRY(8), .PID_W(4)) dut (
        .clk            (clk),
        .rst_L          (rst_L),
        .pause          (pause),
        .txn_start      (txn_start),
        .txn_dir        (txn_dir),
        .txn_done       (txn_done),
        .txn_ok         (txn_ok),
        .tx_token_start (tx_token_start),
        .tx_token_pid   (tx_token_pid),
        .tx_data_start  (tx_data_start),
        .tx_hs_start    (tx_hs_start),
        .tx_hs_pid      (tx_hs_pid),
        .tx_done        (tx_done),
        .rx_start       (rx_start),
        .rx_hs_mode     (rx_hs_mode),
        .rx_success     (rx_success),
        .rx_fail        (rx_fail),
        .rx_pid         (rx_pid),
        .retry_cnt      (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse tallies sampled mid-cycle, away from the active edge.
    int tok_cnt  = 0;
    int data_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (tx_token_start) tok_cnt++;
        if (tx_data_start)  data_cnt++;
        if (txn_done)       done_cnt++;
    end

    typedef struct {
        logic        start;
        logic        dir;
        logic        txd;
        logic        rxs;
        logic        rxf;
        logic [3:0]  rpid;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic dr, input logic txd,
                                input logic rxs, input logic rxf, input logic [3:0] rpid,
                                input logic [5:0] pulses, input logic [3:0] tpid,
                                input logic [3:0] hpid, input logic mode, input logic [3:0] rc);
        vec_t v;
        v.start = st;
        v.dir   = dr;
        v.txd   = txd;
        v.rxs   = rxs;
        v.rxf   = rxf;
        v.rpid  = rpid;
        v.exp   = {pulses, tpid, hpid, mode, rc};
        return v;
    endfunction

    // {tok, data, hs, rx, done, ok, token_pid, hs_pid, hs_mode, retry_cnt}
    function automatic logic [18:0] snap();
        return {tx_token_start, tx_data_start, tx_hs_start, rx_start, txn_done, txn_ok,
                tx_token_pid, tx_hs_pid, rx_hs_mode, retry_cnt};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return tx_token_start;
            1:       return tx_data_start;
            2:       return tx_hs_start;
            3:       return rx_start;
            default: return txn_done;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        txn_start  = 1'b0;
        txn_dir    = 1'b0;
        tx_done    = 1'b0;
        rx_success = 1'b0;
        rx_fail    = 1'b0;
        rx_pid     = 4'b0000;
    endtask

    // Wait up to 20 cycles for the selected output pulse.
    task automatic wait_out(input int sel, input string name);
        int n;
        n = 0;
        #1;
        while (!sig(sel) && n < 20) begin
            tick();
            n++;
        end
        check({"wait_", name}, 32'(sig(sel)), 32'd1);
    endtask

    // One OUT attempt from TOKEN through the handshake response.
    task automatic out_attempt(input logic fail, input logic [3:0] pid);
        wait_out(0, "token");
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_out(1, "data");
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_out(3, "rx_start");
        tick();
        if (fail) begin
            rx_fail = 1'b1;
        end else begin
            rx_success = 1'b1;
            rx_pid     = pid;
        end
        tick();
        clear_in();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int tok_base;
        int data_base;
        int done_base;

        rst_L = 1'b0;
        pause = 1'b0;
        clear_in();

        // Clean OUT transaction.
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b000000, 4'b0001, 4'b0010, 0, 4'd0));
        tbl.push_back(mk(1,0,0,0,0,4'h0, 6'b000000, 4'b0001, 4'b0010, 0, 4'd0));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b100000, 4'b0001, 4'b0010, 1, 4'd0));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b000000, 4'b0001, 4'b0010, 1, 4'd1));
        tbl.push_back(mk(0,0,1,0,0,4'h0, 6'b000000, 4'b0001, 4'b0010, 1, 4'd1));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b010000, 4'b0001, 4'b0010, 1, 4'd1));
        tbl.push_back(mk(0,0,0,1,0,4'h2, 6'b000000, 4'b0001, 4'b0010, 1, 4'd1));
        tbl.push_back(mk(0,0,1,0,0,4'h0, 6'b000000, 4'b0001, 4'b0010, 1, 4'd1));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b000100, 4'b0001, 4'b0010, 1, 4'd1));
        tbl.push_back(mk(0,0,0,1,0,4'h2, 6'b000000, 4'b0001, 4'b0010, 1, 4'd1));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b000011, 4'b0001, 4'b0010, 1, 4'd1));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b000000, 4'b0001, 4'b0010, 1, 4'd1));
        // IN transaction: first receive has success+fail together (-> NAK), then success.
        tbl.push_back(mk(1,1,0,0,0,4'h0, 6'b000000, 4'b0001, 4'b0010, 1, 4'd1));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b100000, 4'b1001, 4'b0010, 0, 4'd0));
        tbl.push_back(mk(0,0,1,0,0,4'h0, 6'b000000, 4'b1001, 4'b0010, 0, 4'd1));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b000100, 4'b1001, 4'b0010, 0, 4'd1));
        tbl.push_back(mk(0,0,0,1,1,4'h2, 6'b000000, 4'b1001, 4'b0010, 0, 4'd1));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b001000, 4'b1001, 4'b1010, 0, 4'd1));
        tbl.push_back(mk(0,0,1,0,0,4'h0, 6'b000000, 4'b1001, 4'b1010, 0, 4'd1));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b000000, 4'b1001, 4'b1010, 0, 4'd1));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b100000, 4'b1001, 4'b1010, 0, 4'd1));
        tbl.push_back(mk(0,0,1,0,0,4'h0, 6'b000000, 4'b1001, 4'b1010, 0, 4'd2));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b000100, 4'b1001, 4'b1010, 0, 4'd2));
        tbl.push_back(mk(0,0,0,1,0,4'h3, 6'b000000, 4'b1001, 4'b1010, 0, 4'd2));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b001000, 4'b1001, 4'b0010, 0, 4'd2));
        tbl.push_back(mk(0,0,1,0,0,4'h0, 6'b000000, 4'b1001, 4'b0010, 0, 4'd2));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b000011, 4'b1001, 4'b0010, 0, 4'd2));
        tbl.push_back(mk(0,0,0,0,0,4'h0, 6'b000000, 4'b1001, 4'b0010, 0, 4'd2));

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(snap()), 32'({6'b000000, 4'b0001, 4'b0010, 1'b0, 4'd0}));
        rst_L = 1'b1;
        tick();

        // Table-driven vectors: drive, settle, compare, advance one clock.
        data_base = data_cnt;
        for (int i = 0; i < tbl.size(); i++) begin
            txn_start  = tbl[i].start;
            txn_dir    = tbl[i].dir;
            tx_done    = tbl[i].txd;
            rx_success = tbl[i].rxs;
            rx_fail    = tbl[i].rxf;
            rx_pid     = tbl[i].rpid;
            #1;
            check($sformatf("vec%0d", i), 32'(snap()), 32'(tbl[i].exp));
            tick();
        end
        clear_in();
        // Rows 0-11 issue one data packet; the IN rows must issue none.
        check("data_pulses_table", 32'(data_cnt - data_base), 32'd1);

        // OUT: NAK, NAK, ACK.
        tok_base  = tok_cnt;
        data_base = data_cnt;
        txn_start = 1'b1;
        txn_dir   = 1'b0;
        tick();
        clear_in();
        out_attempt(1'b0, 4'b1010);
        out_attempt(1'b0, 4'b1010);
        out_attempt(1'b0, 4'b0010);
        check("nak2_done", 32'({txn_done, txn_ok}), 32'b11);
        check("nak2_retry", 32'(retry_cnt), 32'd3);
        tick();
        check("nak2_tokens", 32'(tok_cnt - tok_base), 32'd3);
        check("nak2_data", 32'(data_cnt - data_base), 32'd3);

        // OUT: rx_fail on every attempt exhausts the budget.
        tok_base  = tok_cnt;
        txn_start = 1'b1;
        txn_dir   = 1'b0;
        tick();
        clear_in();
        for (int a = 0; a < 8; a++) begin
            out_attempt(1'b1, 4'b0000);
        end
        check("fail_retry_no_done", 32'(txn_done), 32'd0);
        tick();
        check("fail_done", 32'({txn_done, txn_ok}), 32'b10);
        check("fail_retry", 32'(retry_cnt), 32'd8);
        repeat (3) tick();
        check("fail_tokens", 32'(tok_cnt - tok_base), 32'd8);

        // Pause in TOKEN, ignored txn_start in RX_WAIT, pause in FINISH.
        tok_base  = tok_cnt;
        done_base = done_cnt;
        txn_start = 1'b1;
        txn_dir   = 1'b0;
        tick();
        clear_in();
        pause = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("pause_hold%0d", c), 32'({tx_token_start, retry_cnt}), 32'd0);
            tick();
        end
        pause = 1'b0;
        #1;
        check("pause_release_token", 32'(tx_token_start), 32'd1);
        tick();
        check("pause_after_token", 32'({tx_token_start, retry_cnt}), 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_out(1, "p_data");
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_out(3, "p_rx_start");
        tick();
        txn_start = 1'b1;
        txn_dir   = 1'b1;
        tick();
        clear_in();
        #1;
        check("ignored_start", 32'(snap()), 32'({6'b000000, 4'b0001, 4'b0010, 1'b1, 4'd1}));
        rx_success = 1'b1;
        rx_pid     = 4'b0010;
        tick();
        clear_in();
        pause = 1'b1;
        #1;
        check("pause_finish", 32'(txn_done), 32'd0);
        tick();
        pause = 1'b0;
        #1;
        check("pause_done", 32'({txn_done, txn_ok, retry_cnt}), 32'({2'b11, 4'd1}));
        repeat (5) tick();
        check("pause_tokens", 32'(tok_cnt - tok_base), 32'd1);
        check("pause_dones", 32'(done_cnt - done_base), 32'd1);

        // Async reset during DATA_WAIT.
        done_base = done_cnt;
        txn_start = 1'b1;
        txn_dir   = 1'b0;
        tick();
        clear_in();
        wait_out(0, "r_token");
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        wait_out(1, "r_data");
        tick();
        #1;
        rst_L = 1'b0;
        #1;
        check("reset_mid", 32'(snap()), 32'({6'b000000, 4'b0001, 4'b0010, 1'b0, 4'd0}));
        tx_done = 1'b1;
        tick();
        tick();
        rst_L   = 1'b1;
        tx_done = 1'b0;
        #1;
        check("reset_no_done", 32'(done_cnt - done_base), 32'd0);
        txn_start = 1'b1;
        txn_dir   = 1'b0;
        tick();
        clear_in();
        #1;
        check("restart_token", 32'({tx_token_start, retry_cnt}), 32'({1'b1, 4'd0}));
        tick();
        check("restart_retry", 32'(retry_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
